// File: rtl/alu_chain_ctrl_if.sv
// Request/result bundle for alu_chain_ctrl; oOverflow exists only with ALU_CHAIN_OVF_EN.
// Requester side drives iValid/operands; the controller answers with oReady/oResult/flags/oDone.
interface alu_chain_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int WORDS = 2
);
  logic                     iValid;
  logic                     oReady;
  logic [2:0]               iMode;
  logic [WIDTH*WORDS-1:0]   iOpA;
  logic [WIDTH*WORDS-1:0]   iOpB;
  logic                     iCB_in;
  logic [WIDTH*WORDS-1:0]   oResult;
  logic                     oCB_out;
  logic                     oZero;
  logic                     oDone;
`ifdef ALU_CHAIN_OVF_EN
  logic                     oOverflow;

  modport master (
    output iValid, iMode, iOpA, iOpB, iCB_in,
    input  oReady, oResult, oCB_out, oZero, oDone, oOverflow
  );
  modport slave (
    input  iValid, iMode, iOpA, iOpB, iCB_in,
    output oReady, oResult, oCB_out, oZero, oDone, oOverflow
  );
`else
  modport master (
    output iValid, iMode, iOpA, iOpB, iCB_in,
    input  oReady, oResult, oCB_out, oZero, oDone
  );
  modport slave (
    input  iValid, iMode, iOpA, iOpB, iCB_in,
    output oReady, oResult, oCB_out, oZero, oDone
  );
`endif
endinterface

// File: rtl/alu_chain_ctrl.sv
// Sequences one wide op through a WIDTH-bit ALU, LSW first; oDone WORDS+1 cycles after accept.
// oReady only in IDLE, requests during RUN/DONE are dropped; ALU_CHAIN_OVF_EN adds oOverflow.
module alu_chain_ctrl #(
  parameter int WIDTH = 4,
  parameter int WORDS = 2
) (
  input  logic             iClk,
  input  logic             iRst,
  alu_chain_ctrl_if.slave  bus,
  output logic [WIDTH-1:0] oAluA,
  output logic [WIDTH-1:0] oAluB,
  output logic             oAluCB,
  output logic [2:0]       oAluMode,
  input  logic [WIDTH-1:0] iAluResult,
  input  logic             iAluCB
);

  localparam int TOT  = WIDTH * WORDS;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  localparam logic [2:0] M_ADD = 3'b000;
  localparam logic [2:0] M_SUB = 3'b001;
  localparam logic [2:0] M_NOT = 3'b101;
  localparam logic [2:0] M_INC = 3'b110;
  localparam logic [2:0] M_DEC = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [TOT-1:0]   a_q, a_d;
  logic [TOT-1:0]   b_q, b_d;
  logic [TOT-1:0]   res_q, res_d;
  logic [2:0]       mode_q, mode_d;
  logic             chain_q, chain_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             cb_q, cb_d;
  logic             zero_q, zero_d;
`ifdef ALU_CHAIN_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [WIDTH-1:0] a_word, b_word;
  logic             arith;

  // mode_q only ever holds add or sub for the carry-chained operations
  assign arith = (mode_q == M_ADD) || (mode_q == M_SUB);

  always_comb begin
    a_word = '0;
    b_word = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (idx_q == IDXW'(w)) begin
        a_word = a_q[w*WIDTH +: WIDTH];
        b_word = b_q[w*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      mode_q  <= '0;
      chain_q <= 1'b0;
      idx_q   <= '0;
      cb_q    <= 1'b0;
      zero_q  <= 1'b0;
`ifdef ALU_CHAIN_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      mode_q  <= mode_d;
      chain_q <= chain_d;
      idx_q   <= idx_d;
      cb_q    <= cb_d;
      zero_q  <= zero_d;
`ifdef ALU_CHAIN_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    mode_d   = mode_q;
    chain_d  = chain_q;
    idx_d    = idx_q;
    cb_d     = cb_q;
    zero_d   = zero_q;
`ifdef ALU_CHAIN_OVF_EN
    ovf_d    = ovf_q;
`endif
    oAluA    = '0;
    oAluB    = '0;
    oAluCB   = 1'b0;
    oAluMode = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.iValid) begin
          a_d     = bus.iOpA;
          idx_d   = '0;
          state_d = S_RUN;
          // inc/dec become add/sub of zero with a forced first carry/borrow
          case (bus.iMode)
            M_INC: begin
              mode_d  = M_ADD;
              b_d     = '0;
              chain_d = 1'b1;
            end
            M_DEC: begin
              mode_d  = M_SUB;
              b_d     = '0;
              chain_d = 1'b1;
            end
            M_NOT: begin
              mode_d  = M_NOT;
              b_d     = '0;
              chain_d = 1'b0;
            end
            M_ADD, M_SUB: begin
              mode_d  = bus.iMode;
              b_d     = bus.iOpB;
              chain_d = bus.iCB_in;
            end
            default: begin
              mode_d  = bus.iMode;
              b_d     = bus.iOpB;
              chain_d = 1'b0;
            end
          endcase
        end
      end

      S_RUN: begin
        oAluA    = a_word;
        oAluB    = b_word;
        oAluCB   = arith & chain_q;
        oAluMode = mode_q;
        for (int w = 0; w < WORDS; w++) begin
          if (idx_q == IDXW'(w)) begin
            res_d[w*WIDTH +: WIDTH] = iAluResult;
          end
        end
        chain_d = arith & iAluCB;
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_DONE;
          cb_d    = arith & iAluCB;
          zero_d  = (res_d == '0);
`ifdef ALU_CHAIN_OVF_EN
          // sign bits of the full operands live in the last word
          if (mode_q == M_ADD) begin
            ovf_d = (a_q[TOT-1] == b_q[TOT-1]) && (iAluResult[WIDTH-1] != a_q[TOT-1]);
          end else if (mode_q == M_SUB) begin
            ovf_d = (a_q[TOT-1] != b_q[TOT-1]) && (iAluResult[WIDTH-1] != a_q[TOT-1]);
          end else begin
            ovf_d = 1'b0;
          end
`endif
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.oReady  = (state_q == S_IDLE);
  assign bus.oDone   = (state_q == S_DONE);
  assign bus.oResult = res_q;
  assign bus.oCB_out = cb_q;
  assign bus.oZero   = zero_q;
`ifdef ALU_CHAIN_OVF_EN
  assign bus.oOverflow = ovf_q;
`endif

endmodule

// File: tb/tb_alu_chain_ctrl.sv
// Randomized scoreboard bench for alu_chain_ctrl (WIDTH=4, WORDS=2) with a behavioural 4-bit ALU attached.
// Expected results come from whole-operand arithmetic; a negedge monitor checks every oDone.
module tb_alu_chain_ctrl;

  localparam int WIDTH = 4;
  localparam int WORDS = 2;
  localparam int TOT   = WIDTH * WORDS;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_chain_ctrl_if #(.WIDTH(WIDTH), .WORDS(WORDS)) bus ();

  logic [WIDTH-1:0] alu_a, alu_b, alu_r;
  logic             alu_cbi, alu_cbo;
  logic [2:0]       alu_m;

  alu_chain_ctrl #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .iClk       (clk),
    .iRst       (rst),
    .bus        (bus),
    .oAluA      (alu_a),
    .oAluB      (alu_b),
    .oAluCB     (alu_cbi),
    .oAluMode   (alu_m),
    .iAluResult (alu_r),
    .iAluCB     (alu_cbo)
  );

  // Behavioural stand-in for ALU_nb #(4)
  always_comb begin : alu_nb
    logic [WIDTH:0] t;
    t = '0;
    case (alu_m)
      3'b000: t = {1'b0, alu_a} + {1'b0, alu_b} + {{WIDTH{1'b0}}, alu_cbi};
      3'b001: t = {1'b0, alu_a} - {1'b0, alu_b} - {{WIDTH{1'b0}}, alu_cbi};
      3'b010: t = {1'b0, alu_a & alu_b};
      3'b011: t = {1'b0, alu_a | alu_b};
      3'b100: t = {1'b0, alu_a ^ alu_b};
      3'b101: t = {1'b0, ~alu_a};
      3'b110: t = {1'b0, alu_a} + 1'b1;
      default: t = {1'b0, alu_a} - 1'b1;
    endcase
    alu_r   = t[WIDTH-1:0];
    alu_cbo = t[WIDTH];
  end

  typedef struct {
    logic [TOT-1:0] res;
    logic           cb;
    logic           z;
    logic           ovf;
    int             acc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors   = 0;
  int   checks   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  int   ops_cnt  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input logic [2:0] m, input logic [TOT-1:0] a,
                                 input logic [TOT-1:0] b, input logic cin);
    exp_t           e;
    logic [TOT:0]   full;
    logic [TOT-1:0] be;
    be = (m >= 3'd5) ? '0 : b;
    case (m)
      3'd0: full = {1'b0, a} + {1'b0, b} + {{TOT{1'b0}}, cin};
      3'd1: full = {1'b0, a} - {1'b0, b} - {{TOT{1'b0}}, cin};
      3'd2: full = {1'b0, a & b};
      3'd3: full = {1'b0, a | b};
      3'd4: full = {1'b0, a ^ b};
      3'd5: full = {1'b0, ~a};
      3'd6: full = {1'b0, a} + 1'b1;
      default: full = {1'b0, a} - 1'b1;
    endcase
    e.res = full[TOT-1:0];
    e.cb  = full[TOT];
    e.z   = (e.res == '0);
    if (m == 3'd0 || m == 3'd6)
      e.ovf = (a[TOT-1] == be[TOT-1]) && (e.res[TOT-1] != a[TOT-1]);
    else if (m == 3'd1 || m == 3'd7)
      e.ovf = (a[TOT-1] != be[TOT-1]) && (e.res[TOT-1] != a[TOT-1]);
    else
      e.ovf = 1'b0;
    e.acc = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.oDone) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got oDone=1 required 0 (cycle %0d)", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        chk("result",  bus.oResult, mon_e.res);
        chk("cb_out",  bus.oCB_out, mon_e.cb);
        chk("zero",    bus.oZero,   mon_e.z);
        chk("latency", cyc - mon_e.acc, WORDS);
        chk("alu_drive_done", {alu_a, alu_b, alu_cbi, alu_m}, 0);
`ifdef ALU_CHAIN_OVF_EN
        chk("overflow", bus.oOverflow, mon_e.ovf);
`endif
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.oReady && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.oReady) chk("ready_timeout", bus.oReady, 1);
  endtask

  task automatic issue(input logic [2:0] m, input logic [TOT-1:0] a, input logic [TOT-1:0] b,
                       input logic cin, input bit hold);
    exp_t e;
    int   n;
    wait_ready();
    bus.iValid = 1'b1;
    bus.iMode  = m;
    bus.iOpA   = a;
    bus.iOpB   = b;
    bus.iCB_in = cin;
    @(posedge clk);
    #1;
    e     = model(m, a, b, cin);
    e.acc = cyc;
    sb_q.push_back(e);
    ops_cnt++;
    // scramble the inputs to show the operands were latched
    bus.iMode  = 3'($urandom_range(0, 7));
    bus.iOpA   = TOT'($urandom);
    bus.iOpB   = TOT'($urandom);
    bus.iCB_in = 1'($urandom);
    if (!hold) begin
      bus.iValid = 1'b0;
    end else begin
      n = 0;
      while (!bus.oReady && n < 20) begin
        n++;
        @(posedge clk);
        #1;
      end
      bus.iValid = 1'b0;
      chk("ready_low_cycles", n, WORDS + 1);
    end
  endtask

  initial begin
    int d0;
    int n;
    rst        = 1'b1;
    bus.iValid = 1'b0;
    bus.iMode  = '0;
    bus.iOpA   = '0;
    bus.iOpB   = '0;
    bus.iCB_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready",  bus.oReady,  1);
    chk("rst_done",   bus.oDone,   0);
    chk("rst_result", bus.oResult, 0);
    chk("rst_cb",     bus.oCB_out, 0);
    chk("rst_zero",   bus.oZero,   0);
    chk("rst_alu",    {alu_a, alu_b, alu_cbi, alu_m}, 0);
    rst = 1'b0;

    issue(3'd0, 8'h5F, 8'h21, 1'b0, 1'b0);
    issue(3'd1, 8'h00, 8'h01, 1'b0, 1'b0);
    issue(3'd1, 8'h10, 8'h01, 1'b0, 1'b0);
    issue(3'd6, 8'hFF, 8'h5A, 1'b0, 1'b0);
    issue(3'd7, 8'h00, 8'hA5, 1'b1, 1'b0);
    issue(3'd2, 8'hA5, 8'h0F, 1'b1, 1'b0);
    issue(3'd4, 8'hFF, 8'hFF, 1'b0, 1'b0);
    issue(3'd5, 8'h3C, 8'hFF, 1'b1, 1'b0);
    issue(3'd3, 8'h81, 8'h18, 1'b0, 1'b0);
    issue(3'd0, 8'hFF, 8'h00, 1'b1, 1'b0);
    issue(3'd1, 8'h00, 8'h00, 1'b1, 1'b0);
    issue(3'd0, 8'h7F, 8'h01, 1'b0, 1'b0);
    issue(3'd1, 8'h80, 8'h01, 1'b0, 1'b0);

    issue(3'd0, 8'h12, 8'h34, 1'b0, 1'b1);

    // abort: reset in the first RUN cycle must suppress oDone
    wait_ready();
    bus.iValid = 1'b1;
    bus.iMode  = 3'd0;
    bus.iOpA   = 8'h11;
    bus.iOpB   = 8'h22;
    bus.iCB_in = 1'b0;
    @(posedge clk);
    #1;
    bus.iValid = 1'b0;
    rst        = 1'b1;
    d0         = done_cnt;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_ready",  bus.oReady,  1);
    chk("abort_result", bus.oResult, 0);
    chk("abort_cb",     bus.oCB_out, 0);
    chk("abort_zero",   bus.oZero,   0);
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt - d0, 0);

    for (int i = 0; i < 60; i++) begin
      issue(3'($urandom_range(0, 7)), TOT'($urandom), TOT'($urandom), 1'($urandom),
            ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #0;
    end

    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", sb_q.size(), 0);
    chk("done_count", done_cnt, ops_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_chain_ctrl.md
Name: alu_chain_ctrl

Overview:
Upstream sequencing stage for the combinational N-bit ALU (ALU_nb). Accepts one wide operation (WIDTH*WORDS bits) via a valid/ready handshake. Drives the ALU one WIDTH-bit word per cycle, LSW first, and chains carry/borrow between words. Collects the result words into a wide result register with carry/borrow-out and zero flags, so a narrow ALU can perform wide arithmetic and logic.

Parameters:
WIDTH, 4, ALU data width per word; must match the attached ALU_nb parameter
WORDS, 2, number of words per operation (>=1); operand width = WIDTH*WORDS

Ports:
iClk  input  1  clock, all state updates on rising edge
iRst  input  1  synchronous, active-high reset
iValid  input  1  operation request
oReady  output  1  high when idle and able to accept a request
iMode  input  3  ALU_nb mode encoding (000 add … 111 decrement)
iOpA  input  WIDTH*WORDS  operand A
iOpB  input  WIDTH*WORDS  operand B (ignored for modes 101/110/111)
iCB_in  input  1  carry-in (add) / borrow-in (sub); ignored for other modes
oAluA  output  WIDTH  ALU A input for the current word
oAluB  output  WIDTH  ALU B input for the current word
oAluCB  output  1  ALU carry/borrow-in for the current word
oAluMode  output  3  ALU mode for the current word
iAluResult  input  WIDTH  ALU result (combinational, same cycle)
iAluCB  input  1  ALU carry/borrow-out (combinational, same cycle)
oResult  output  WIDTH*WORDS  assembled result, held until next accept
oCB_out  output  1  final carry/borrow-out; 0 for logic modes
oZero  output  1  1 when oResult == 0
oDone  output  1  one-cycle pulse, result valid

Behaviour:
- Reset (iRst=1 at edge): state IDLE; oResult=0, oCB_out=0, oZero=0, oDone=0, oReady=1, word index=0. Reset during RUN or DONE aborts the operation with no oDone.
- ALU drive outputs are 0 in IDLE and DONE.
- FSM states IDLE, RUN, DONE.
  - IDLE: oReady=1. On iValid=1 at an edge: latch iOpA, iOpB, iCB_in and the effective mode; clear index; go to RUN. iValid=0 keeps IDLE.
  - RUN: oReady=0. Each cycle present word[index] of A and B, the effective mode, and the chain bit. At the edge: store iAluResult into oResult slice [index]; store iAluCB into the chain bit; index+1. After index==WORDS-1 is captured, go to DONE.
  - DONE: oDone=1 for exactly one cycle; oZero and oCB_out valid; next state IDLE.
- Latency: accept edge → WORDS RUN cycles → DONE cycle. oDone is high in cycle WORDS+1 after accept. Throughput is one operation per WORDS+2 cycles.
- Mode mapping (effective mode and B word):
  - 000 add: chain starts at iCB_in.
  - 001 sub: chain starts at iCB_in as borrow.
  - 010/011/100 logic: per word, oAluCB=0, oCB_out forced 0.
  - 101 complement: per word, B=0, oCB_out=0.
  - 110 increment: issued as mode 000 with B=0 and first-word carry-in=1; chained.
  - 111 decrement: issued as mode 001 with B=0 and first-word borrow-in=1; chained.
- oCB_out = chain bit after the last word (modes 000/001/110/111 only).
- oResult is not modified between DONE and the next accept. Partial words are visible during RUN, and only DONE-qualified values are valid.
- iValid during RUN/DONE is ignored and not queued.
- WORDS=1: a single RUN cycle, then DONE.
- Arithmetic wraps modulo 2^(WIDTH*WORDS).

Optional Feature:
ALU_CHAIN_OVF_EN — when defined, adds output port oOverflow (1 bit), registered with the result and valid in DONE.
- Add-type (000, 110): oOverflow = (A msb == B msb) && (result msb != A msb).
- Sub-type (001, 111): oOverflow = (A msb != B msb) && (result msb != A msb).
- B is the effective B (0 for inc/dec). Logic modes: 0.
- Reset value: 0.
When not defined, the port and its logic are absent. All other behaviour is identical.

Test Plan:
- WIDTH=4, WORDS=2, bench instantiates ALU_nb #(4) on the oAlu*/iAlu* ports for all scenarios.
- add 0x5F+0x21, cin=0 → oResult=0x80, oCB_out=0, oZero=0, oDone exactly 3 cycles after the accept edge; with ALU_CHAIN_OVF_EN, oOverflow=1.
- sub 0x00-0x01, borrow=0 → oResult=0xFF, oCB_out=1. sub 0x10-0x01 → oResult=0x0F, oCB_out=0; the borrow must chain from word 0 to word 1.
- increment 0xFF → oResult=0x00, oCB_out=1, oZero=1. decrement 0x00 → 0xFF, oCB_out=1.
- AND 0xA5&0x0F → 0x05, oCB_out=0. XOR 0xFF^0xFF → 0x00, oZero=1. complement 0x3C → 0xC3.
- Handshake/reset:
  - iValid held high through RUN: exactly one operation executes, and oReady is low for 3 cycles.
  - iRst asserted in the first RUN cycle: next cycle IDLE, oReady=1, oResult=0, and no oDone pulse.
